// File: rtl/ctrl_seq_pkg.sv
// Shared defines for the control sequencer: widths, opcodes,
// FSM states and the wb_sel / alu_op / pc_sel code points.
package ctrl_seq_pkg;

  localparam int WORD_LEN     = 16;
  localparam int REG_ADDR_LEN = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC1 = 2'd2;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_NAND = 2'd1;
  localparam logic [1:0] ALU_PASS = 2'd2;
  localparam logic [1:0] ALU_EQ   = 2'd3;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_REL = 2'd1;
  localparam logic [1:0] PC_REG = 2'd2;

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction/data memory request-acknowledge handshake
// between the sequencer (master) and the memories (slave).
interface ctrl_seq_if;
  import ctrl_seq_pkg::*;

  logic imem_req;
  logic imem_ack;
  logic dmem_rd;
  logic dmem_wr;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_rd,
    output dmem_wr,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_rd,
    input  dmem_wr,
    output imem_ack,
    output dmem_ack
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control decoder: register addresses,
// ALU controls and opcode class flags for the sequencer FSM.
module ctrl_decode #(
  parameter int WORD_LEN     = ctrl_seq_pkg::WORD_LEN,
  parameter int REG_ADDR_LEN = ctrl_seq_pkg::REG_ADDR_LEN
) (
  input  logic [WORD_LEN-1:0]     instr,
  output logic [REG_ADDR_LEN-1:0] src1,
  output logic [REG_ADDR_LEN-1:0] src2,
  output logic [REG_ADDR_LEN-1:0] tgt,
  output logic [1:0]              alu_op,
  output logic                    alu_imm,
  output logic                    is_lw,
  output logic                    is_sw,
  output logic                    is_beq,
  output logic                    is_jalr,
  output logic                    bad_jalr
);
  import ctrl_seq_pkg::*;

  opcode_e    op;
  logic [6:0] imm7;
  logic       use_rc;

  assign op   = opcode_e'(instr[15:13]);
  assign imm7 = instr[6:0];

  assign tgt  = REG_ADDR_LEN'(instr[12:10]);
  assign src1 = REG_ADDR_LEN'(instr[9:7]);
  assign src2 = use_rc ? REG_ADDR_LEN'(instr[2:0])
                       : REG_ADDR_LEN'(instr[12:10]);

  // A JALR with a nonzero offset is the halt encoding.
  assign bad_jalr = is_jalr && (imm7 != 7'd0);

  always_comb begin
    alu_op  = ALU_ADD;
    alu_imm = 1'b0;
    use_rc  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_jalr = 1'b0;
    unique case (1'b1)
      op == OP_ADD: use_rc = 1'b1;
      op == OP_ADDI: alu_imm = 1'b1;
      op == OP_NAND: begin
        alu_op = ALU_NAND;
        use_rc = 1'b1;
      end
      op == OP_LUI: alu_op = ALU_PASS;
      op == OP_SW: begin
        alu_imm = 1'b1;
        is_sw   = 1'b1;
      end
      op == OP_LW: begin
        alu_imm = 1'b1;
        is_lw   = 1'b1;
      end
      op == OP_BEQ: begin
        alu_op = ALU_EQ;
        is_beq = 1'b1;
      end
      op == OP_JALR: begin
        alu_op  = ALU_PASS;
        is_jalr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM,
// retired-instruction counter and sticky halt flag.
module ctrl_seq #(
  parameter int WORD_LEN     = ctrl_seq_pkg::WORD_LEN,
  parameter int REG_ADDR_LEN = ctrl_seq_pkg::REG_ADDR_LEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_LEN-1:0]     instr,
  input  logic                    eq,
  ctrl_seq_if.master              mem,
  output logic                    ir_en,
  output logic [REG_ADDR_LEN-1:0] src1,
  output logic [REG_ADDR_LEN-1:0] src2,
  output logic [REG_ADDR_LEN-1:0] tgt,
  output logic                    reg_wr_en,
  output logic [1:0]              wb_sel,
  output logic [1:0]              alu_op,
  output logic                    alu_imm,
  output logic                    pc_en,
  output logic [1:0]              pc_sel,
  output logic                    halted,
  output logic [WORD_LEN-1:0]     retired
);
  import ctrl_seq_pkg::*;

  state_e state, state_n;

  logic [REG_ADDR_LEN-1:0] d_src1, d_src2, d_tgt;
  logic [1:0] d_alu_op;
  logic d_alu_imm;
  logic is_lw, is_sw, is_beq, is_jalr, bad_jalr;

  logic req_c, ird_c, iwr_c, ir_c;
  logic rwe_c, pce_c;
  logic [1:0] wbs_c, pcs_c;

  logic [WORD_LEN-1:0] retired_q;
  logic halted_q;

  ctrl_decode #(
    .WORD_LEN     (WORD_LEN),
    .REG_ADDR_LEN (REG_ADDR_LEN)
  ) u_dec (
    .instr    (instr),
    .src1     (d_src1),
    .src2     (d_src2),
    .tgt      (d_tgt),
    .alu_op   (d_alu_op),
    .alu_imm  (d_alu_imm),
    .is_lw    (is_lw),
    .is_sw    (is_sw),
    .is_beq   (is_beq),
    .is_jalr  (is_jalr),
    .bad_jalr (bad_jalr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    req_c   = 1'b0;
    ir_c    = 1'b0;
    ird_c   = 1'b0;
    iwr_c   = 1'b0;
    rwe_c   = 1'b0;
    pce_c   = 1'b0;
    wbs_c   = WB_ALU;
    pcs_c   = PC_INC;
    unique case (state)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem.imem_ack) begin
          ir_c    = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: state_n = bad_jalr ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_n = S_MEM;
        end else if (is_beq) begin
          pce_c   = 1'b1;
          pcs_c   = eq ? PC_REL : PC_INC;
          state_n = S_FETCH;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        ird_c = is_lw;
        iwr_c = is_sw;
        if (mem.dmem_ack) begin
          if (is_lw) begin
            state_n = S_WB;
          end else begin
            pce_c   = 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      S_WB: begin
        rwe_c   = 1'b1;
        pce_c   = 1'b1;
        pcs_c   = is_jalr ? PC_REG : PC_INC;
        wbs_c   = is_lw ? WB_MEM : (is_jalr ? WB_PC1 : WB_ALU);
        state_n = S_FETCH;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  // Everything is forced low while rst is held, including the
  // FETCH request that the reset state would otherwise raise.
  assign mem.imem_req = req_c & ~rst;
  assign mem.dmem_rd  = ird_c & ~rst;
  assign mem.dmem_wr  = iwr_c & ~rst;
  assign ir_en        = ir_c & ~rst;
  assign reg_wr_en    = rwe_c & ~rst;
  assign pc_en        = pce_c & ~rst;
  assign pc_sel       = rst ? PC_INC : pcs_c;
  assign wb_sel       = rst ? WB_ALU : wbs_c;
  assign alu_op       = rst ? ALU_ADD : d_alu_op;
  assign alu_imm      = d_alu_imm & ~rst;
  assign src1         = rst ? '0 : d_src1;
  assign src2         = rst ? '0 : d_src2;
  assign tgt          = rst ? '0 : d_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        retired_q <= '0;
    else if (pc_en) retired_q <= retired_q + WORD_LEN'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    halted_q <= 1'b0;
    else if (state_n == S_HALT) halted_q <= 1'b1;
  end

  assign retired = retired_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq with an expected-result scoreboard.
module tb_ctrl_seq;
  import ctrl_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        eq;
  logic        ir_en, reg_wr_en, alu_imm, pc_en, halted;
  logic [2:0]  src1, src2, tgt;
  logic [1:0]  wb_sel, alu_op, pc_sel;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_ret;

  typedef struct packed {
    logic       rwe;
    logic [1:0] wbs;
    logic [1:0] pcs;
    logic [1:0] aop;
    logic       aimm;
    logic [2:0] tgt;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [7:0] cyc;
    logic [7:0] mcyc;
    logic [7:0] rq;
  } exp_t;

  exp_t sb[$];

  ctrl_seq_if bus();

  always #5 clk = ~clk;

  ctrl_seq dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .eq        (eq),
    .mem       (bus),
    .ir_en     (ir_en),
    .src1      (src1),
    .src2      (src2),
    .tgt       (tgt),
    .reg_wr_en (reg_wr_en),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .alu_imm   (alu_imm),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .halted    (halted),
    .retired   (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ins, input logic eqv,
                                 input int fdly, input int dly);
    exp_t e;
    logic [2:0] op;
    e   = '0;
    op  = ins[15:13];
    e.tgt = ins[12:10];
    e.s1  = ins[9:7];
    e.s2  = (op == 3'd0 || op == 3'd2) ? ins[2:0] : ins[12:10];
    e.rwe = !(op == 3'd4 || op == 3'd6);
    e.wbs = (op == 3'd5) ? 2'd1 : (op == 3'd7) ? 2'd2 : 2'd0;
    e.pcs = (op == 3'd6) ? {1'b0, eqv} : (op == 3'd7) ? 2'd2 : 2'd0;
    case (op)
      3'd0: begin e.aop = 2'd0; e.aimm = 1'b0; end
      3'd1: begin e.aop = 2'd0; e.aimm = 1'b1; end
      3'd2: begin e.aop = 2'd1; e.aimm = 1'b0; end
      3'd3: begin e.aop = 2'd2; e.aimm = 1'b0; end
      3'd4: begin e.aop = 2'd0; e.aimm = 1'b1; end
      3'd5: begin e.aop = 2'd0; e.aimm = 1'b1; end
      3'd6: begin e.aop = 2'd3; e.aimm = 1'b0; end
      default: begin e.aop = 2'd2; e.aimm = 1'b0; end
    endcase
    e.mcyc = (op == 3'd4 || op == 3'd5) ? 8'(dly + 1) : 8'd0;
    e.rq   = 8'(fdly + 1);
    if (op == 3'd6)      e.cyc = 8'(fdly + 3);
    else if (op == 3'd4) e.cyc = 8'(fdly + 4 + dly);
    else if (op == 3'd5) e.cyc = 8'(fdly + 5 + dly);
    else                 e.cyc = 8'(fdly + 4);
    return e;
  endfunction

  // Starts and ends on a negedge with the DUT in FETCH.
  task automatic run(input logic [15:0] ins, input logic eqv,
                     input int fdly, input int dly);
    exp_t e;
    int   cyc, mc, rq;
    bit   done;
    cyc  = 0;
    mc   = 0;
    rq   = 0;
    done = 1'b0;
    sb.push_back(model(ins, eqv, fdly, dly));
    instr = ins;
    eq    = eqv;
    while (!done && cyc < 64) begin
      if (bus.imem_req) begin
        rq++;
        bus.imem_ack = (rq > fdly);
      end else begin
        bus.imem_ack = 1'b1;
      end
      if (bus.dmem_rd || bus.dmem_wr) begin
        mc++;
        bus.dmem_ack = (mc > dly);
      end else begin
        bus.dmem_ack = 1'b1;
      end
      #1;
      cyc++;
      if (pc_en) begin
        e = sb.pop_front();
        chk("reg_wr_en", reg_wr_en, e.rwe);
        chk("wb_sel", wb_sel, e.wbs);
        chk("pc_sel", pc_sel, e.pcs);
        chk("alu_op", alu_op, e.aop);
        chk("alu_imm", alu_imm, e.aimm);
        chk("tgt", tgt, e.tgt);
        chk("src1", src1, e.s1);
        chk("src2", src2, e.s2);
        chk("cycles", cyc, e.cyc);
        chk("mem_cycles", mc, e.mcyc);
        chk("req_cycles", rq, e.rq);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      chk("pc_en_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      exp_ret = exp_ret + 16'd1;
    end
    #1;
    chk("retired", retired, exp_ret);
  endtask

  initial begin
    rst = 1'b1;
    instr = 16'h0503;
    eq = 1'b0;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    exp_ret = 16'd0;

    @(negedge clk);
    #1;
    chk("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_ir_en", ir_en, 1'b0);
    chk("rst_dmem", {bus.dmem_rd, bus.dmem_wr}, 2'b00);
    chk("rst_strobes", {pc_en, reg_wr_en}, 2'b00);
    chk("rst_addr", {src1, src2, tgt}, 9'd0);
    chk("rst_retired", retired, 16'd0);
    chk("rst_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    chk("release_imem_req", bus.imem_req, 1'b1);

    run(16'h0503, 1'b0, 0, 0);
    run(16'hA505, 1'b0, 0, 3);
    run(16'hC57F, 1'b1, 0, 0);
    run(16'hC57F, 1'b0, 0, 0);
    run(16'h8501, 1'b0, 0, 0);
    run(16'h5286, 1'b0, 0, 0);
    run(16'h3CFD, 1'b0, 0, 0);
    run(16'h6C55, 1'b0, 0, 0);
    run(16'hEA80, 1'b0, 0, 0);
    run(16'h1D82, 1'b0, 2, 0);
    run(16'h8E81, 1'b0, 0, 2);

    // Reset in the middle of a store access.
    instr = 16'h8501;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 10 && !bus.dmem_wr; i++) begin
      @(negedge clk);
      #1;
    end
    chk("sw_dmem_wr", bus.dmem_wr, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_sw_dmem_wr", bus.dmem_wr, 1'b0);
    chk("rst_sw_retired", retired, 16'd0);
    chk("rst_sw_imem_req", bus.imem_req, 1'b0);
    exp_ret = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_imem_req", bus.imem_req, 1'b1);
    chk("post_rst_dmem_wr", bus.dmem_wr, 1'b0);
    @(negedge clk);

    // JALR with nonzero imm7 halts.
    instr = 16'hE001;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("decode_halted", halted, 1'b0);
    @(negedge clk);
    #1;
    chk("halt_halted", halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack = i[0];
      bus.dmem_ack = ~i[0];
      @(negedge clk);
      #1;
      chk("halt_imem_req", bus.imem_req, 1'b0);
      chk("halt_outs",
          {ir_en, pc_en, reg_wr_en, bus.dmem_rd, bus.dmem_wr}, 5'd0);
    end
    chk("halt_sticky", halted, 1'b1);
    chk("halt_retired", retired, exp_ret);
    rst = 1'b1;
    #1;
    chk("unhalt", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;

    // Preload the counter near the top to reach the wrap quickly.
    force dut.retired_q = 16'hFFFD;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFD;
    chk("preload", retired, exp_ret);
    @(negedge clk);
    for (int i = 0; i < 4; i++) run(16'h0503, 1'b0, 0, 0);
    chk("wrapped", retired, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter WORD_LEN, default 16: instruction and counter width.
REQ-002 Parameter REG_ADDR_LEN, default 3: register address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the posedge
- rst  in  1  asynchronous active-high reset
- instr  in  WORD_LEN  instruction register contents, valid from DECODE onward
- eq  in  1  ALU equality flag, sampled in EXEC
- imem_ack  in  1  instruction fetch complete
- dmem_ack  in  1  data access complete
- imem_req  out  1  fetch request
- ir_en  out  1  instruction register load strobe
- dmem_rd / dmem_wr  out  1 each  data read/write request
- src1 / src2 / tgt  out  REG_ADDR_LEN each  register file read/write addresses
- reg_wr_en  out  1  register file write enable
- wb_sel  out  2  write-back source: 0 ALU, 1 MEM, 2 PC+1
- alu_op  out  2  ALU operation: 0 ADD, 1 NAND, 2 PASS (LUI), 3 EQ
- alu_imm  out  1  ALU B operand is the sign-extended imm7
- pc_en  out  1  PC load strobe
- pc_sel  out  2  next PC: 0 PC+1, 1 PC+1+imm7, 2 register (JALR)
- halted  out  1  sticky halt flag
- retired  out  WORD_LEN  retired-instruction count

Function
REQ-005 Decoding SHALL be: opcode = instr[15:13]; rA = [12:10]; rB = [9:7]; rC = [2:0]; imm7 = [6:0], signed. Opcodes: ADD 0, ADDI 1, NAND 2, LUI 3, SW 4, LW 5, BEQ 6, JALR 7.
REQ-006 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT, and SHALL be Moore except for the eq-dependent pc_sel in EXEC.
REQ-007 FETCH SHALL hold imem_req=1 until imem_ack=1; in the ack cycle it SHALL assert ir_en=1 and go to DECODE.
REQ-008 DECODE SHALL last one cycle and go to EXEC; a JALR with imm7 != 0 SHALL instead go to HALT.
REQ-009 src1 SHALL equal rB. src2 SHALL equal rC for ADD/NAND and rA otherwise. tgt SHALL equal rA. All three are valid from DECODE until leaving WB/MEM.
REQ-010 EXEC SHALL last one cycle, with transitions as follows:
- LW/SW go to MEM.
- BEQ: pc_en=1; pc_sel=1 if eq=1, else 0; go to FETCH.
- All other opcodes go to WB.
REQ-011 MEM SHALL hold dmem_rd (LW) or dmem_wr (SW) until dmem_ack=1. On ack, LW goes to WB; SW asserts pc_en=1, pc_sel=0 and goes to FETCH.
REQ-012 WB SHALL last exactly one cycle, so exactly one register file negedge write occurs:
- reg_wr_en=1 and pc_en=1.
- pc_sel=2 for JALR, else 0.
- wb_sel=1 for LW, 2 for JALR, else 0.
- Then go to FETCH.
REQ-013 reg_wr_en SHALL be asserted even when tgt=0; the register file discards writes to R0.
REQ-014 alu_op/alu_imm SHALL be: ADD 0/0, NAND 1/0, ADDI 0/1, LW/SW 0/1, LUI 2/0, BEQ 3/0, JALR 2/0.
REQ-015 retired SHALL increment by 1, wrapping from 0xFFFF to 0, on every cycle in which pc_en=1.
REQ-016 HALT SHALL be absorbing: halted=1 and all request, strobe and enable outputs 0 until reset.
REQ-017 An ack arriving in a state that does not request it SHALL be ignored.

Reset
REQ-018 rst=1 SHALL immediately force the state to FETCH, retired to 0 and halted to 0. While rst=1, all outputs (including imem_req) SHALL be 0.
REQ-019 A reset mid-access (MEM or FETCH) SHALL abandon the access; the first cycle after release SHALL assert imem_req=1.

Structure
REQ-020 Opcodes, state encodings and the wb_sel/alu_op/pc_sel codes SHALL live in the shared defines file, beside WORD_LEN and REG_ADDR_LEN.
REQ-021 Opcode-to-control decoding SHALL be one combinational sub-module, ctrl_decode; the FSM, counter and halt flag SHALL live in ctrl_seq.

Verification
REQ-022 ADD r1,r2,r3 (0x0503) with imem_ack high -> FETCH, DECODE, EXEC, WB. In WB: reg_wr_en=1, tgt=1, src1=2, src2=3, wb_sel=0. retired goes 0->1.
REQ-023 LW r1,r2,5 (0xA505) with dmem_ack delayed 3 cycles -> dmem_rd high for 4 cycles, then one WB cycle with wb_sel=1 and alu_imm=1.
REQ-024 BEQ r1,r2,-1 (0xC57F): eq=1 -> pc_sel=1 and pc_en=1 in EXEC, no reg_wr_en; repeat with eq=0 -> pc_sel=0.
REQ-025 JALR with imm7=1 (0xE001) -> HALT. halted=1, and imem_req stays 0 for 20 further cycles with imem_ack toggling.
REQ-026 rst pulsed mid-SW (dmem_wr=1) -> dmem_wr falls with no clock edge, retired=0, and imem_req=1 the cycle after release. Also 65536 ADDs -> retired wraps to 0.
